cordic_job_scheduler: RTL

Job sequencer in front of the CORDIC engine in the TinyQV CORDIC peripheral. It accepts CORDIC jobs into a command FIFO and launches them one at a time on the single engine. Each job carries mode, rotating flag, shift, A and B. Outputs are captured into a result FIFO, so software can batch several operations and drain the results later. Sits between the peripheral register decoder and the engine instance.

---
 rtl/cordic_sched_pkg.sv | 40 ++++
 rtl/cordic_sched_fifo.sv | 57 +++++
 rtl/cordic_job_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cordic_sched_pkg.sv
// Shared types for the CORDIC job scheduler: mode encodings, FSM states and FIFO entry layouts.
// The cmd/res entries carry a 4-bit tag only when CORDIC_SCHED_TAG_EN is defined.
package cordic_sched_pkg;

  localparam int FIXED_WIDTH = 16;
  localparam int SHIFT_W     = 4;
  localparam int TAG_W       = 4;

  typedef enum logic [1:0] {
    MODE_CIRCULAR   = 2'd0,
    MODE_LINEAR     = 2'd1,
    MODE_HYPERBOLIC = 2'd2
  } cordic_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } sched_state_e;

  typedef struct packed {
`ifdef CORDIC_SCHED_TAG_EN
    logic [TAG_W-1:0]       tag;
`endif
    cordic_mode_e           mode;
    logic                   rotating;
    logic [SHIFT_W-1:0]     shift;
    logic [FIXED_WIDTH-1:0] a;
    logic [FIXED_WIDTH-1:0] b;
  } cmd_entry_t;

  typedef struct packed {
`ifdef CORDIC_SCHED_TAG_EN
    logic [TAG_W-1:0]       tag;
`endif
    logic [FIXED_WIDTH-1:0] out1;
    logic [FIXED_WIDTH-1:0] out2;
  } res_entry_t;

endpackage

// File: rtl/cordic_sched_fifo.sv
// Synchronous FIFO with occupancy count and synchronous flush; DEPTH must be a power of two.
// Push while full, pop while empty, and any push/pop during flush are ignored.
module cordic_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // NOTE: state registers use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is not reset; an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/cordic_job_scheduler.sv
// Queues CORDIC jobs, launches them one at a time on the engine and buffers results.
// Optional CORDIC_SCHED_TAG_EN adds cmd_tag/res_tag carried alongside each job.
module cordic_job_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_mode,
  input  logic                   cmd_rotating,
  input  logic [SHIFT_W-1:0]     cmd_shift,
  input  logic [FIXED_WIDTH-1:0] cmd_a,
  input  logic [FIXED_WIDTH-1:0] cmd_b,
`ifdef CORDIC_SCHED_TAG_EN
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic [TAG_W-1:0]       res_tag,
`endif
  output logic                   eng_start,
  output logic [1:0]             eng_mode,
  output logic                   eng_rotating,
  output logic [SHIFT_W-1:0]     eng_shift,
  output logic [FIXED_WIDTH-1:0] eng_a,
  output logic [FIXED_WIDTH-1:0] eng_b,
  input  logic [FIXED_WIDTH-1:0] eng_out1,
  input  logic [FIXED_WIDTH-1:0] eng_out2,
  input  logic                   eng_done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [FIXED_WIDTH-1:0] res_out1,
  output logic [FIXED_WIDTH-1:0] res_out2,
  output logic                   busy,
  output logic [CNT_W-1:0]       cmd_count,
  output logic [CNT_W-1:0]       res_count,
  output logic                   irq
);

  cmd_entry_t   cmd_wdata, cmd_head, eng_q;
  res_entry_t   res_wdata, res_head;
  logic         cmd_full, cmd_empty, res_full, res_empty;
  logic         launch, res_push;
  sched_state_e state_q;
  logic         eng_start_q, drop_q, irq_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cmd_wdata          = '0;
    cmd_wdata.mode     = cordic_mode_e'(cmd_mode);
    cmd_wdata.rotating = cmd_rotating;
    cmd_wdata.shift    = cmd_shift;
    cmd_wdata.a        = cmd_a;
    cmd_wdata.b        = cmd_b;
`ifdef CORDIC_SCHED_TAG_EN
    cmd_wdata.tag      = cmd_tag;
`endif
    res_wdata          = '0;
    res_wdata.out1     = eng_out1;
    res_wdata.out2     = eng_out2;
`ifdef CORDIC_SCHED_TAG_EN
    res_wdata.tag      = eng_q.tag;
`endif
  end

  // Launching only while a result slot is free reserves that slot for the job in flight.
  assign launch   = (state_q == ST_IDLE) && !cmd_empty && !res_full && !flush;
  assign res_push = (state_q == ST_WAIT) && eng_done && !drop_q && !flush;

  cordic_sched_fifo #(.WIDTH($bits(cmd_entry_t)), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (cmd_valid),
    .wdata (cmd_wdata),
    .pop   (launch),
    .rdata (cmd_head),
    .count (cmd_count),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  cordic_sched_fifo #(.WIDTH($bits(res_entry_t)), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (res_push),
    .wdata (res_wdata),
    .pop   (res_ready),
    .rdata (res_head),
    .count (res_count),
    .full  (res_full),
    .empty (res_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      eng_q       <= '0;
      eng_start_q <= 1'b0;
      drop_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      irq_q       <= res_push;
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            eng_q       <= cmd_head;
            eng_start_q <= 1'b1;
            state_q     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          state_q <= ST_WAIT;
          if (flush) drop_q <= 1'b1;
        end
        ST_WAIT: begin
          // A flushed job still runs to completion; its done pulse only clears the drop flag.
          if (eng_done) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready    = !cmd_full;
  assign res_valid    = !res_empty;
  assign res_out1     = res_empty ? '0 : res_head.out1;
  assign res_out2     = res_empty ? '0 : res_head.out2;
`ifdef CORDIC_SCHED_TAG_EN
  assign res_tag      = res_empty ? '0 : res_head.tag;
`endif
  assign eng_start    = eng_start_q;
  assign eng_mode     = eng_q.mode;
  assign eng_rotating = eng_q.rotating;
  assign eng_shift    = eng_q.shift;
  assign eng_a        = eng_q.a;
  assign eng_b        = eng_q.b;
  assign busy         = (state_q != ST_IDLE);
  assign irq          = irq_q;

endmodule
